// File: rtl/pmem_responder.sv
// Fixed-latency physical-memory model answering cache line reads/writes over a held-request handshake.
// Optional protocol-violation flag enabled by defining PMEM_ERROR_CHECK_EN.
module pmem_responder #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned LINES   = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic         pmem_resp,
  output logic [127:0] pmem_rdata,
  output logic         pmem_error
);

  localparam int unsigned IDX_W  = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned LINE_W = 128;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic                is_write_q, is_write_d;
  logic                resp_q, resp_d;
  logic [LINE_W-1:0]   rdata_q, rdata_d;

  logic [LINE_W-1:0]   mem [LINES];
  logic [IDX_W-1:0]    addr_idx_c;
  logic                req_held_c;
  logic                unused_addr_c;

  assign addr_idx_c    = pmem_address[4 +: IDX_W];
  assign unused_addr_c = ^{pmem_address[3:0], pmem_address[15:4+IDX_W]};

`ifdef PMEM_ERROR_CHECK_EN
  logic err_q, err_d;
`endif

  // Next-state: capture in IDLE, count down in BUSY (abort if request dropped), pulse in RESP.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    resp_d     = 1'b0;
    rdata_d    = rdata_q;
    req_held_c = is_write_q ? pmem_write : pmem_read;
`ifdef PMEM_ERROR_CHECK_EN
    err_d      = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (pmem_read || pmem_write) begin
          idx_d      = addr_idx_c;
          wdata_d    = pmem_wdata;
          is_write_d = pmem_write;
`ifdef PMEM_ERROR_CHECK_EN
          if (pmem_read && pmem_write) err_d = 1'b1;
`endif
          if (LATENCY <= 1) begin
            state_d = RESP;
            resp_d  = 1'b1;
            if (!pmem_write) rdata_d = mem[addr_idx_c];
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        if (!req_held_c) begin
          state_d = IDLE;
          cnt_d   = '0;
`ifdef PMEM_ERROR_CHECK_EN
          err_d   = 1'b1;
`endif
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d = RESP;
          cnt_d   = '0;
          resp_d  = 1'b1;
          if (!is_write_q) rdata_d = mem[idx_q];
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      resp_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      resp_q     <= resp_d;
      rdata_q    <= rdata_d;
    end
  end

  // Line storage is deliberately not reset; a write lands on the edge leaving RESP.
  always_ff @(posedge clk) begin
    if (state_q == RESP && is_write_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

`ifdef PMEM_ERROR_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
  assign pmem_error = err_q;
`else
  assign pmem_error = 1'b0;
`endif

  assign pmem_resp  = resp_q;
  assign pmem_rdata = rdata_q;

endmodule

// File: tb/tb_pmem_responder.sv
// Randomized bench for pmem_responder: a LATENCY=4/LINES=32 and a LATENCY=1/LINES=8 instance
// checked against a line-array reference model.
module tb_pmem_responder;

`ifdef PMEM_ERROR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic [1:0]   rd, wr, resp, err;
  logic [15:0]  addr  [2];
  logic [127:0] wdata [2];
  logic [127:0] rdata [2];

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] mdl_mem [2][32];
  logic [127:0] mdl_rdata [2];
  bit           mdl_err [2];

  pmem_responder #(.LATENCY(4), .LINES(32)) dut0 (
    .clk(clk), .reset(reset), .pmem_read(rd[0]), .pmem_write(wr[0]),
    .pmem_address(addr[0]), .pmem_wdata(wdata[0]), .pmem_resp(resp[0]),
    .pmem_rdata(rdata[0]), .pmem_error(err[0])
  );

  pmem_responder #(.LATENCY(1), .LINES(8)) dut1 (
    .clk(clk), .reset(reset), .pmem_read(rd[1]), .pmem_write(wr[1]),
    .pmem_address(addr[1]), .pmem_wdata(wdata[1]), .pmem_resp(resp[1]),
    .pmem_rdata(rdata[1]), .pmem_error(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int u);
    return (u == 0) ? 4 : 1;
  endfunction

  function automatic int lines_of(input int u);
    return (u == 0) ? 32 : 8;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One request, starting and ending at a negedge with the responder idle.
  // drop_at > 0 withdraws the request after that many edges (counting the acceptance edge).
  task automatic txn(input int u, input bit rd_i, input bit wr_i, input logic [15:0] a,
                     input logic [127:0] d, input int drop_at);
    int  idx;
    int  lat;
    bit  seen;
    bit  is_wr;
    lat   = lat_of(u);
    idx   = int'(a >> 4) % lines_of(u);
    is_wr = wr_i;
    seen  = 1'b0;
    rd[u] = rd_i; wr[u] = wr_i; addr[u] = a; wdata[u] = d;
    if (rd_i && wr_i) mdl_err[u] = mdl_err[u] | ERR_EN;
    for (int k = 1; k <= lat + 3 && !seen; k++) begin
      @(posedge clk);
      #1;
      addr[u]  = 16'($urandom);
      wdata[u] = rnd128();
      @(negedge clk);
      if (resp[u]) begin
        seen = 1'b1;
        chk("resp_latency", 128'(k), 128'(lat));
        if (!is_wr) begin
          mdl_rdata[u] = mdl_mem[u][idx];
          chk("rdata", rdata[u], mdl_rdata[u]);
        end
        rd[u] = 1'b0; wr[u] = 1'b0;
        @(negedge clk);
        chk("resp_one_cycle", 128'(resp[u]), 128'(0));
        chk("rdata_hold", rdata[u], mdl_rdata[u]);
        if (is_wr) mdl_mem[u][idx] = d;
      end else if (k == drop_at) begin
        rd[u] = 1'b0; wr[u] = 1'b0;
      end
    end
    if (drop_at > 0) begin
      chk("abort_no_resp", 128'(seen), 128'(0));
      chk("abort_rdata", rdata[u], mdl_rdata[u]);
      mdl_err[u] = mdl_err[u] | ERR_EN;
    end else if (!seen) begin
      chk("resp_timeout", 128'(0), 128'(1));
      rd[u] = 1'b0; wr[u] = 1'b0;
      @(negedge clk);
    end
    chk("error_flag", 128'(err[u]), 128'(mdl_err[u]));
  endtask

  initial begin
    logic [127:0] pat;
    logic [127:0] old20;
    int           u;
    int           op;
    int           drop;

    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
      mdl_rdata[i] = '0; mdl_err[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_resp", 128'(resp[i]), 128'(0));
      chk("reset_rdata", rdata[i], 128'(0));
      chk("reset_error", 128'(err[i]), 128'(0));
    end
    reset = 1'b0;
    @(negedge clk);

    // Fill every line so the model is fully known.
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < lines_of(i); j++)
        txn(i, 1'b0, 1'b1, 16'(j << 4), rnd128(), 0);

    // Write then read same line with different low nibble.
    pat = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    txn(0, 1'b0, 1'b1, 16'h0040, pat, 0);
    txn(0, 1'b1, 1'b0, 16'h004E, '0, 0);
    chk("write_read_0040", rdata[0], pat);

    // Alias wrap over 32 lines.
    pat = {16{8'hA5}};
    txn(0, 1'b0, 1'b1, 16'h0010, pat, 0);
    txn(0, 1'b1, 1'b0, 16'h0210, '0, 0);
    chk("alias_0210", rdata[0], pat);

    // Back-to-back write-back then fill, then read the written line.
    pat = rnd128();
    txn(0, 1'b0, 1'b1, 16'h0080, pat, 0);
    txn(0, 1'b1, 1'b0, 16'h0100, '0, 0);
    txn(0, 1'b1, 1'b0, 16'h0080, '0, 0);
    chk("b2b_readback_0080", rdata[0], pat);

    // Read withdrawn two cycles after acceptance.
    txn(0, 1'b1, 1'b0, 16'h0060, '0, 2);

    // Reset in the middle of a write's BUSY window.
    old20 = mdl_mem[0][2];
    rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 16'h0020; wdata[0] = ~old20;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    wr[0] = 1'b0;
    chk("midbusy_reset_resp", 128'(resp[0]), 128'(0));
    chk("midbusy_reset_rdata", rdata[0], 128'(0));
    chk("midbusy_reset_error", 128'(err[0]), 128'(0));
    @(negedge clk);
    reset = 1'b0;
    mdl_rdata[0] = '0; mdl_rdata[1] = '0;
    mdl_err[0] = 1'b0; mdl_err[1] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_reset_no_resp", 128'(resp[0]), 128'(0));
    end
    txn(0, 1'b1, 1'b0, 16'h0020, '0, 0);
    chk("survive_reset_0020", rdata[0], old20);

    // LATENCY=1 with read and write both high is a write.
    pat = rnd128();
    txn(1, 1'b1, 1'b1, 16'h0030, pat, 0);
    txn(1, 1'b1, 1'b0, 16'h0030, '0, 0);
    chk("both_high_is_write", rdata[1], pat);

    for (int n = 0; n < 80; n++) begin
      u    = int'($urandom_range(0, 1));
      op   = int'($urandom_range(0, 9));
      drop = (u == 0 && $urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      txn(u, (op < 5) || (op == 9), op >= 5, 16'($urandom), rnd128(), drop);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
